// File: rtl/vend_fsm.sv
// Coin-accumulating vending controller: nickel/dime buttons build credit
// toward a fixed 25-cent price; dispenses on reaching it and returns a
// nickel when the final dime overshoots to 30 cents.
module vend_fsm (
    input  logic clk,
    input  logic rst,
    input  logic nb,
    input  logic db,
    output logic s,
    output logic r
);

    // Credit in cents; encoding is the natural 0..6 order.
    typedef enum logic [2:0] {
        S0  = 3'd0,
        S5  = 3'd1,
        S10 = 3'd2,
        S15 = 3'd3,
        S20 = 3'd4,
        S25 = 3'd5,
        S30 = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_nb_q;
    logic   r_db_q;
    logic   w_nick;
    logic   w_dime;

    // Rising-edge detect so a held button is credited only once.
    assign w_nick = nb & ~r_nb_q;
    assign w_dime = db & ~r_db_q;

    // State and previous button levels; reset discards any credit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S0;
            r_nb_q  <= 1'b0;
            r_db_q  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_nb_q  <= nb;
            r_db_q  <= db;
        end
    end

    // Next-state and Moore output decode; a dime wins over a simultaneous nickel.
    always_comb begin
        w_next = S0;
        s      = 1'b0;
        r      = 1'b0;
        case (r_state)
            S0: begin
                if (w_dime)      w_next = S10;
                else if (w_nick) w_next = S5;
                else             w_next = S0;
            end
            S5: begin
                if (w_dime)      w_next = S15;
                else if (w_nick) w_next = S10;
                else             w_next = S5;
            end
            S10: begin
                if (w_dime)      w_next = S20;
                else if (w_nick) w_next = S15;
                else             w_next = S10;
            end
            S15: begin
                if (w_dime)      w_next = S25;
                else if (w_nick) w_next = S20;
                else             w_next = S15;
            end
            S20: begin
                if (w_dime)      w_next = S30;
                else if (w_nick) w_next = S25;
                else             w_next = S20;
            end
            // Sale cycle: coins arriving now are swallowed, not credited.
            S25: begin
                w_next = S0;
                s      = 1'b1;
            end
            S30: begin
                w_next = S0;
                s      = 1'b1;
                r      = 1'b1;
            end
            // Unused encoding recovers to empty credit with outputs idle.
            default: begin
                w_next = S0;
            end
        endcase
    end

endmodule

// File: tb/tb_vend_fsm.sv
// Scoreboard bench for vend_fsm. Each table row packs
// {rst, nb, db, expected_state[2:0], expected_s, expected_r}; the expected
// part is queued when the row is driven and popped once the edge has passed.
module tb_vend_fsm;

    logic clk;
    logic rst;
    logic nb;
    logic db;
    logic s;
    logic r;

    int total;
    int bad;
    logic [4:0] expq[$];

    vend_fsm dut (
        .clk (clk),
        .rst (rst),
        .nb  (nb),
        .db  (db),
        .s   (s),
        .r   (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one row of stimulus, queue its expectation, step one clock.
    task automatic drive(input logic [7:0] v);
        rst = v[7];
        nb  = v[6];
        db  = v[5];
        expq.push_back(v[4:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] t [4] = '{8'b0_1_1_000_00, 8'b0_1_1_000_00,
                              8'b1_0_0_000_00, 8'b1_0_0_000_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic [7:0] t [4] = '{8'b0_1_0_000_00, 8'b1_1_0_001_00,
                              8'b1_1_0_001_00, 8'b1_0_0_001_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL held_reset step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_exact();
        logic [7:0] t [7] = '{8'b0_0_0_000_00, 8'b1_1_0_001_00, 8'b1_0_0_001_00,
                              8'b1_0_1_011_00, 8'b1_0_0_011_00, 8'b1_0_1_101_10,
                              8'b1_0_0_000_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL exact step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_overpay();
        logic [7:0] t [7] = '{8'b0_0_0_000_00, 8'b1_0_1_010_00, 8'b1_0_0_010_00,
                              8'b1_0_1_100_00, 8'b1_0_0_100_00, 8'b1_0_1_110_11,
                              8'b1_0_0_000_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL overpay step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_held_button();
        logic [7:0] t [7] = '{8'b0_0_0_000_00, 8'b1_1_0_001_00, 8'b1_1_0_001_00,
                              8'b1_1_0_001_00, 8'b1_1_0_001_00, 8'b1_1_0_001_00,
                              8'b1_0_0_001_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL held_button step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] t [4] = '{8'b0_0_0_000_00, 8'b1_1_1_010_00,
                              8'b1_0_0_010_00, 8'b1_1_0_011_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL simultaneous step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] t [8] = '{8'b0_0_0_000_00, 8'b1_1_0_001_00, 8'b1_0_0_001_00,
                              8'b1_0_1_011_00, 8'b1_0_0_011_00, 8'b0_0_0_000_00,
                              8'b1_0_0_000_00, 8'b1_1_0_001_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mid_reset step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_ignored_during_sale();
        logic [7:0] t [9] = '{8'b0_0_0_000_00, 8'b1_0_1_010_00, 8'b1_0_0_010_00,
                              8'b1_0_1_100_00, 8'b1_0_0_100_00, 8'b1_1_0_101_10,
                              8'b1_0_1_000_00, 8'b1_0_1_000_00, 8'b1_0_0_000_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL ignored_sale step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] t [11] = '{8'b0_0_0_000_00, 8'b1_0_1_010_00, 8'b1_0_0_010_00,
                               8'b1_0_1_100_00, 8'b1_0_0_100_00, 8'b1_0_1_110_11,
                               8'b1_1_0_000_00, 8'b1_0_1_010_00, 8'b1_1_0_011_00,
                               8'b1_0_1_101_10, 8'b1_0_0_000_00};
        logic [4:0] e;
        logic [4:0] o;
        for (int i = 0; i < $size(t); i++) begin
            drive(t[i]);
            e = expq.pop_front();
            o = {dut.r_state, s, r};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL back_to_back step %0d: got st=%0d s=%b r=%b want st=%0d s=%b r=%b",
                         i, o[4:2], o[1], o[0], e[4:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        nb    = 1'b0;
        db    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_held_through_reset();
        test_exact();
        test_overpay();
        test_held_button();
        test_simultaneous();
        test_mid_reset();
        test_ignored_during_sale();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
